// File: rtl/seg7_scan_controller.sv
// Time-multiplexed hex 7-segment scanner with double-buffered display value,
// leading-zero blanking, per-digit enables and PWM brightness.
module seg7_scan_controller #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CLK_DIV    = 50000,
  parameter int unsigned DUTY_BITS  = 4,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic [DUTY_BITS-1:0]    brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic                    frame_tick
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IW = $clog2(NUM_DIGITS);

  logic [PW-1:0]           pcnt_q, pcnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DUTY_BITS-1:0]    dcnt_q, dcnt_d;
  logic                    pend_q, pend_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic                    tick_q, tick_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic                  pcnt_wrap, frame_wrap;
  logic [3:0]            cur_nib;
  logic                  cur_dp, cur_en, cur_blank, zero_above, lit;
  logic [NUM_DIGITS-1:0] an_act;
  logic [6:0]            seg_act;

  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    case (n)
      4'h0: hex_decode = 7'h7E;
      4'h1: hex_decode = 7'h30;
      4'h2: hex_decode = 7'h6D;
      4'h3: hex_decode = 7'h79;
      4'h4: hex_decode = 7'h33;
      4'h5: hex_decode = 7'h5B;
      4'h6: hex_decode = 7'h5F;
      4'h7: hex_decode = 7'h70;
      4'h8: hex_decode = 7'h7F;
      4'h9: hex_decode = 7'h7B;
      4'hA: hex_decode = 7'h77;
      4'hB: hex_decode = 7'h1F;
      4'hC: hex_decode = 7'h4E;
      4'hD: hex_decode = 7'h3D;
      4'hE: hex_decode = 7'h4F;
      default: hex_decode = 7'h47;
    endcase
  endfunction

  always_comb begin
    pcnt_wrap  = (pcnt_q == PW'(CLK_DIV - 1));
    frame_wrap = pcnt_wrap && (idx_q == IW'(NUM_DIGITS - 1));
    pcnt_d     = pcnt_wrap ? '0 : pcnt_q + 1'b1;
    idx_d      = idx_q;
    if (pcnt_wrap) idx_d = frame_wrap ? '0 : idx_q + 1'b1;
    dcnt_d     = dcnt_q + 1'b1;
    tick_d     = frame_wrap;

    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    // A load coinciding with the wrap bypasses pending straight into the display.
    if (frame_wrap) begin
      pend_d = 1'b0;
      if (load) begin
        disp_val_d = value;
        disp_dp_d  = dp_in;
      end else if (pend_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
      end
    end else if (load) begin
      pend_d     = 1'b1;
      pend_val_d = value;
      pend_dp_d  = dp_in;
    end
  end

  // Walk digits from the most significant down so zero_above covers N-1..i.
  always_comb begin
    zero_above = 1'b1;
    cur_nib    = '0;
    cur_dp     = 1'b0;
    cur_en     = 1'b0;
    cur_blank  = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      zero_above = zero_above && (disp_val_q[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
      if (idx_q == IW'(NUM_DIGITS - 1 - k)) begin
        cur_nib   = disp_val_q[4*(NUM_DIGITS-1-k) +: 4];
        cur_dp    = disp_dp_q[NUM_DIGITS-1-k];
        cur_en    = digit_en[NUM_DIGITS-1-k];
        cur_blank = blank_lz && zero_above && (k != NUM_DIGITS - 1);
      end
    end
  end

  always_comb begin
    lit     = cur_en && (dcnt_q < brightness);
    an_act  = (lit && (pcnt_q != '0)) ? (NUM_DIGITS'(1) << idx_q) : '0;
    seg_act = (lit && !cur_blank) ? hex_decode(cur_nib) : '0;
    an_d    = ACTIVE_LOW ? ~an_act : an_act;
    seg_d   = ACTIVE_LOW ? ~seg_act : seg_act;
    dp_d    = ACTIVE_LOW ? ~(lit && cur_dp) : (lit && cur_dp);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q     <= '0;
      idx_q      <= '0;
      dcnt_q     <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      tick_q     <= 1'b0;
      an_q       <= ACTIVE_LOW ? '1 : '0;
      seg_q      <= ACTIVE_LOW ? '1 : '0;
      dp_q       <= ACTIVE_LOW;
    end else begin
      pcnt_q     <= pcnt_d;
      idx_q      <= idx_d;
      dcnt_q     <= dcnt_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      tick_q     <= tick_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign AN         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Bench for seg7_scan_controller: directed scenarios plus random traffic,
// every output cycle checked against a timeline-based reference model.
module tb_seg7_scan_controller;

  localparam int ND = 4;
  localparam int CD = 8;
  localparam int DB = 2;
  localparam int FRAME = ND * CD;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   value = '0;
  logic          load = 1'b0;
  logic [3:0]    dp_in = '0;
  logic [3:0]    digit_en = 4'hF;
  logic          blank_lz = 1'b0;
  logic [DB-1:0] brightness = 2'd3;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    AN;
  logic          frame_tick;

  seg7_scan_controller #(
    .NUM_DIGITS(ND), .CLK_DIV(CD), .DUTY_BITS(DB), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .dp_in(dp_in),
    .digit_en(digit_en), .blank_lz(blank_lz), .brightness(brightness),
    .seg(seg), .dp(dp), .AN(AN), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: cycle count since reset release plus the two display buffers.
  int          t;
  logic [15:0] m_disp, m_pendv;
  logic [3:0]  m_disp_dp, m_pend_dp;
  bit          m_pend;

  string SEGS [16] = '{"ABCDEF", "BC", "ABDEG", "ABCDG", "BCFG", "ACDFG", "ACDEFG", "ABC",
                      "ABCDEFG", "ABCDFG", "ABCEFG", "CDEFG", "ADEF", "BCDEG", "ADEFG", "AEFG"};

  function automatic logic [6:0] glyph(input int n);
    string s;
    logic [6:0] r;
    s = SEGS[n];
    r = '0;
    for (int k = 0; k < s.len(); k++) r[6 - int'(s[k] - 8'h41)] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; m_disp = '0; m_disp_dp = '0; m_pendv = '0; m_pend_dp = '0; m_pend = 0;
  endtask

  task automatic tick();
    int pc, ix, dc, nib;
    bit wrap, on, blank;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp;
    pc    = t % CD;
    ix    = (t / CD) % ND;
    dc    = t % (1 << DB);
    wrap  = (t % FRAME) == FRAME - 1;
    nib   = int'((m_disp >> (4 * ix)) & 16'hF);
    on    = digit_en[ix] && (dc < int'(brightness));
    blank = blank_lz && ix >= 1 && ((m_disp >> (4 * ix)) == 16'h0);
    e_an  = (on && pc != 0) ? ~(4'b0001 << ix) : 4'hF;
    e_seg = (on && !blank) ? ~glyph(nib) : 7'h7F;
    e_dp  = on ? ~m_disp_dp[ix] : 1'b1;
    if (wrap) begin
      if (load) begin m_disp = value; m_disp_dp = dp_in; end
      else if (m_pend) begin m_disp = m_pendv; m_disp_dp = m_pend_dp; end
      m_pend = 0;
    end else if (load) begin
      m_pendv = value; m_pend_dp = dp_in; m_pend = 1;
    end
    @(posedge clk);
    #1;
    chk("AN", 32'(AN), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("frame_tick", 32'(frame_tick), 32'(wrap));
    t++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic run_to_wrap_cycle();
    for (int k = 0; k < 2 * FRAME && (t % FRAME) != FRAME - 1; k++) tick();
    chk("wrap_reached", 32'((t % FRAME) == FRAME - 1), 32'd1);
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_AN"}, 32'(AN), 32'hF);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_dp"}, 32'(dp), 32'd1);
    chk({tag, "_ft"}, 32'(frame_tick), 32'd0);
  endtask

  initial begin
    #100000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // 1: reset state, then scan from digit 0
    repeat (3) @(posedge clk);
    #1 chk_dark("reset");
    @(negedge clk) reset = 1'b1;
    model_reset();
    tick();
    tick();
    chk("first_digit0", 32'(AN), 32'hE);
    run(2 * FRAME);

    // 2: 12AF shown after the next wrap
    do_load(16'h12AF, 4'b0000);
    run(2 * FRAME);

    // 3: last load wins; load on the wrap cycle takes effect immediately
    do_load(16'h0000, 4'b0001);
    run(3);
    do_load(16'h5000, 4'b1000);
    run(FRAME + 4);
    run_to_wrap_cycle();
    do_load(16'h9C3D, 4'b0110);
    run(FRAME);

    // 4: leading-zero blanking
    blank_lz = 1'b1;
    do_load(16'h0030, 4'b0100);
    run(2 * FRAME);
    do_load(16'h0000, 4'b0000);
    run(2 * FRAME);
    blank_lz = 1'b0;

    // 5: brightness 0 and sparse digit enables
    brightness = 2'd0;
    run(FRAME + 3);
    brightness = 2'd3;
    digit_en = 4'b0101;
    run(FRAME + 5);
    digit_en = 4'hF;

    // random traffic
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) brightness = DB'($urandom);
      if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 31) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 11) == 0) begin
        value = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
        dp_in = 4'($urandom);
        load = 1'b1;
      end
      tick();
      load = 1'b0;
    end

    // 6: asynchronous reset mid-slot on digit 2
    brightness = 2'd3; digit_en = 4'hF; blank_lz = 1'b0;
    do_load(16'h4321, 4'b1111);
    for (int k = 0; k < 3 * FRAME && !(((t / CD) % ND) == 2 && (t % CD) == 3); k++) tick();
    chk("slot2_reached", 32'(((t / CD) % ND) == 2 && (t % CD) == 3), 32'd1);
    tick();
    #2 reset = 1'b0;
    #1 chk_dark("async_reset");
    @(posedge clk);
    #1 chk_dark("held_reset");
    @(negedge clk) reset = 1'b1;
    model_reset();
    run(2 * FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
